sprite_hit_multi: RTL and testbench

SPRITE_HIT_MULTI -- requirements
Module: sprite_hit_multi

---
 rtl/ppu_hit_pkg.sv | 13 +
 rtl/hit_qualify.sv | 40 ++++
 rtl/sprite_hit_multi.sv | 114 +++++++++++
 tb/tb_sprite_hit_multi.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ppu_hit_pkg.sv
// ppu_hit_pkg: shared encodings and column constants for the sprite hit detector.
package ppu_hit_pkg;
    localparam logic [1:0] MODE_S0_BG  = 2'd0;
    localparam logic [1:0] MODE_ANY_BG = 2'd1;
    localparam logic [1:0] MODE_SPR    = 2'd2;
    localparam logic [1:0] MODE_ALT    = 2'd3;
    localparam logic [1:0] RSEL_STAT   = 2'd0;
    localparam logic [1:0] RSEL_MASK   = 2'd1;
    localparam logic [1:0] RSEL_FH     = 2'd2;
    localparam logic [1:0] RSEL_FV     = 2'd3;
    localparam int unsigned CLIP_COL   = 8;
    localparam int unsigned EXCL_COL   = 255;
endpackage

// File: rtl/hit_qualify.sv
// hit_qualify: per-pixel opacity clipping (stage-1 input side) and event-mask
// formation by mode (stage-2 side); purely combinational.
module hit_qualify
    import ppu_hit_pkg::*;
#(
    parameter int NCH = 8,
    parameter int BGW = 2,
    parameter int HW  = 9
) (
    input  logic [BGW-1:0] bgc,
    input  logic [NCH-1:0] spr_opaq,
    input  logic           clip_bg,
    input  logic           clip_spr,
    input  logic [HW-1:0]  h_in,
    output logic           bg_qual,
    output logic [NCH-1:0] spr_qual,
    input  logic           s1_val,
    input  logic           s1_vis,
    input  logic [HW-1:0]  s1_h,
    input  logic [1:0]     s1_mode,
    input  logic           s1_bg,
    input  logic [NCH-1:0] s1_spr,
    output logic [NCH-1:0] ev
);
    logic in_clip;
    logic multi;

    always_comb begin
        in_clip  = h_in < HW'(CLIP_COL);
        bg_qual  = (|bgc) && !(clip_bg && in_clip);
        spr_qual = (clip_spr && in_clip) ? '0 : spr_opaq;
        multi    = $countones(s1_spr) >= 2;
        ev       = '0;
        // Column 255 never reports a hit, whatever the mode.
        if (s1_val && s1_vis && s1_h != HW'(EXCL_COL))
            ev = (s1_mode == MODE_S0_BG) ? NCH'(s1_spr[0] & s1_bg) :
                 (s1_mode == MODE_SPR)   ? (multi ? s1_spr : '0) :
                                           (s1_spr & {NCH{s1_bg}});
    end
endmodule

// File: rtl/sprite_hit_multi.sv
// sprite_hit_multi: two-stage sprite collision detector with sticky flags,
// first-hit capture, saturating hit counter and a register read port.
module sprite_hit_multi
    import ppu_hit_pkg::*;
#(
    parameter int NCH = 8,
    parameter int BGW = 2,
    parameter int HW  = 9,
    parameter int VW  = 9,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           PCLK,
    input  logic           n_RES,
    input  logic [BGW-1:0] BGC,
    input  logic [NCH-1:0] SPR_OPAQ,
    input  logic           VIS,
    input  logic           CLIP_BG,
    input  logic           CLIP_SPR,
    input  logic [HW-1:0]  H,
    input  logic [VW-1:0]  V,
    input  logic [1:0]     MODE,
    input  logic           RESCL,
    input  logic           RD,
    input  logic [1:0]     RSEL,
    output logic           HIT,
    output logic [NCH-1:0] HIT_MASK,
    output logic [HW-1:0]  FIRST_H,
    output logic [VW-1:0]  FIRST_V,
    output logic [CW-1:0]  FIRST_CH,
    output logic [7:0]     HIT_CNT,
    output logic [7:0]     DB_out,
    output logic           DB_oe
);
    logic           val_q, val_d, vis_q, vis_d, bg_q, bg_d;
    logic [HW-1:0]  h_q, h_d, first_h_q, first_h_d;
    logic [VW-1:0]  v_q, v_d, first_v_q, first_v_d;
    logic [1:0]     mode_q, mode_d;
    logic [NCH-1:0] spr_q, spr_d, mask_q, mask_d, ev;
    logic [CW-1:0]  first_ch_q, first_ch_d, lo;
    logic [7:0]     cnt_q, cnt_d;
    logic           bg_qual, take;
    logic [NCH-1:0] spr_qual;

    hit_qualify #(.NCH(NCH), .BGW(BGW), .HW(HW)) u_qual (
        .bgc(BGC), .spr_opaq(SPR_OPAQ), .clip_bg(CLIP_BG), .clip_spr(CLIP_SPR),
        .h_in(H), .bg_qual(bg_qual), .spr_qual(spr_qual),
        .s1_val(val_q), .s1_vis(vis_q), .s1_h(h_q), .s1_mode(mode_q),
        .s1_bg(bg_q), .s1_spr(spr_q), .ev(ev)
    );

    always_comb begin
        lo = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (ev[i]) lo = CW'(i);
        val_d      = !RESCL;
        vis_d      = VIS;
        h_d        = H;
        v_d        = V;
        mode_d     = MODE;
        bg_d       = bg_qual;
        spr_d      = spr_qual;
        take       = (|ev) && !(|mask_q);
        mask_d     = RESCL ? '0 : (mask_q | ev);
        first_h_d  = RESCL ? '0 : (take ? h_q : first_h_q);
        first_v_d  = RESCL ? '0 : (take ? v_q : first_v_q);
        first_ch_d = RESCL ? '0 : (take ? lo : first_ch_q);
        cnt_d      = RESCL ? '0 : ((|ev) && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
    end

    always_ff @(posedge PCLK or negedge n_RES) begin
        if (!n_RES) begin
            val_q      <= 1'b0;
            vis_q      <= 1'b0;
            h_q        <= '0;
            v_q        <= '0;
            mode_q     <= '0;
            bg_q       <= 1'b0;
            spr_q      <= '0;
            mask_q     <= '0;
            first_h_q  <= '0;
            first_v_q  <= '0;
            first_ch_q <= '0;
            cnt_q      <= '0;
        end else begin
            val_q      <= val_d;
            vis_q      <= vis_d;
            h_q        <= h_d;
            v_q        <= v_d;
            mode_q     <= mode_d;
            bg_q       <= bg_d;
            spr_q      <= spr_d;
            mask_q     <= mask_d;
            first_h_q  <= first_h_d;
            first_v_q  <= first_v_d;
            first_ch_q <= first_ch_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        HIT      = |mask_q;
        HIT_MASK = mask_q;
        FIRST_H  = first_h_q;
        FIRST_V  = first_v_q;
        FIRST_CH = first_ch_q;
        HIT_CNT  = cnt_q;
        DB_oe    = RD;
        DB_out   = !RD                ? 8'h00 :
                   (RSEL == RSEL_STAT) ? {HIT, cnt_q == 8'hFF, 6'b0} :
                   (RSEL == RSEL_MASK) ? 8'(mask_q) :
                   (RSEL == RSEL_FH)   ? 8'(first_h_q) :
                                         8'(first_v_q);
    end
endmodule

// File: tb/tb_sprite_hit_multi.sv
// tb_sprite_hit_multi: directed checks of the sprite hit detector with NCH=8.
module tb_sprite_hit_multi;
    logic       PCLK = 1'b0;
    logic       n_RES = 1'b0;
    logic [1:0] BGC = '0;
    logic [7:0] SPR_OPAQ = '0;
    logic       VIS = 1'b0, CLIP_BG = 1'b0, CLIP_SPR = 1'b0;
    logic [8:0] H = '0, V = '0;
    logic [1:0] MODE = '0, RSEL = '0;
    logic       RESCL = 1'b0, RD = 1'b0;
    logic       HIT, DB_oe;
    logic [7:0] HIT_MASK, HIT_CNT, DB_out;
    logic [8:0] FIRST_H, FIRST_V;
    logic [2:0] FIRST_CH;
    int n_cmp = 0;
    int n_err = 0;

    sprite_hit_multi dut (
        .PCLK(PCLK), .n_RES(n_RES), .BGC(BGC), .SPR_OPAQ(SPR_OPAQ), .VIS(VIS),
        .CLIP_BG(CLIP_BG), .CLIP_SPR(CLIP_SPR), .H(H), .V(V), .MODE(MODE),
        .RESCL(RESCL), .RD(RD), .RSEL(RSEL), .HIT(HIT), .HIT_MASK(HIT_MASK),
        .FIRST_H(FIRST_H), .FIRST_V(FIRST_V), .FIRST_CH(FIRST_CH),
        .HIT_CNT(HIT_CNT), .DB_out(DB_out), .DB_oe(DB_oe)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic pix(input logic [1:0] m, input logic [1:0] bgc, input logic [7:0] spr,
                       input logic [8:0] h, input logic [8:0] v);
        MODE = m; BGC = bgc; SPR_OPAQ = spr; H = h; V = v; VIS = 1'b1;
        step();
    endtask

    task automatic idle();
        VIS = 1'b0; SPR_OPAQ = '0; BGC = '0; H = 9'd300;
        step();
    endtask

    task automatic clear();
        VIS = 1'b0; RESCL = 1'b1;
        step();
        RESCL = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_hit"}, 32'(HIT), 0);
        chk({tag, "_mask"}, 32'(HIT_MASK), 0);
        chk({tag, "_cnt"}, 32'(HIT_CNT), 0);
        chk({tag, "_fh"}, 32'(FIRST_H), 0);
        chk({tag, "_fv"}, 32'(FIRST_V), 0);
        chk({tag, "_fch"}, 32'(FIRST_CH), 0);
    endtask

    initial begin
        step();
        all_zero("reset");
        chk("reset_oe", 32'(DB_oe), 0);
        chk("reset_db", 32'(DB_out), 0);
        n_RES = 1'b1;
        step();

        // Mode 0 single pixel, two-edge latency
        pix(2'd0, 2'd1, 8'h01, 9'd20, 9'd30);
        VIS = 1'b0;
        chk("m0_lat1", 32'(HIT), 0);
        idle();
        chk("m0_hit", 32'(HIT), 1);
        chk("m0_fh", 32'(FIRST_H), 20);
        chk("m0_fv", 32'(FIRST_V), 30);
        chk("m0_fch", 32'(FIRST_CH), 0);
        chk("m0_cnt", 32'(HIT_CNT), 1);
        chk("m0_mask", 32'(HIT_MASK), 8'h01);
        clear();
        all_zero("rescl");

        // Mode 1 two pixels
        pix(2'd1, 2'd1, 8'h24, 9'd40, 9'd50);
        pix(2'd1, 2'd1, 8'h01, 9'd41, 9'd51);
        idle();
        chk("m1_mask", 32'(HIT_MASK), 8'h25);
        chk("m1_fch", 32'(FIRST_CH), 2);
        chk("m1_fh", 32'(FIRST_H), 40);
        chk("m1_fv", 32'(FIRST_V), 50);
        chk("m1_cnt", 32'(HIT_CNT), 2);
        RD = 1'b1; RSEL = 2'd1; #1;
        chk("rd_oe", 32'(DB_oe), 1);
        chk("rd_mask", 32'(DB_out), 8'h25);
        RSEL = 2'd2; #1;
        chk("rd_fh", 32'(DB_out), 40);
        RSEL = 2'd3; #1;
        chk("rd_fv", 32'(DB_out), 50);
        RSEL = 2'd0; #1;
        chk("rd_stat", 32'(DB_out), 8'h80);
        idle();
        chk("rd_nomod", 32'(HIT_CNT), 2);
        RD = 1'b0; #1;
        chk("rd_off", 32'(DB_out), 0);
        chk("rd_off_oe", 32'(DB_oe), 0);
        clear();

        // Mode 3 behaves as mode 1; a MODE change only affects new pixels
        pix(2'd3, 2'd1, 8'h02, 9'd60, 9'd61);
        pix(2'd0, 2'd1, 8'h02, 9'd62, 9'd61);
        idle();
        chk("m3_mask", 32'(HIT_MASK), 8'h02);
        chk("m3_cnt", 32'(HIT_CNT), 1);
        clear();

        // Clip and excluded column boundaries
        CLIP_BG = 1'b1;
        pix(2'd1, 2'd3, 8'hFF, 9'd5, 9'd1);
        CLIP_BG = 1'b0; CLIP_SPR = 1'b1;
        pix(2'd1, 2'd3, 8'hFF, 9'd7, 9'd1);
        CLIP_SPR = 1'b0;
        pix(2'd1, 2'd3, 8'hFF, 9'd255, 9'd1);
        idle();
        chk("bnd_nohit", 32'(HIT), 0);
        chk("bnd_nocnt", 32'(HIT_CNT), 0);
        CLIP_BG = 1'b1;
        pix(2'd1, 2'd3, 8'hFF, 9'd8, 9'd2);
        CLIP_BG = 1'b0;
        idle();
        chk("bnd_h8_hit", 32'(HIT), 1);
        chk("bnd_h8_fh", 32'(FIRST_H), 8);
        chk("bnd_h8_mask", 32'(HIT_MASK), 8'hFF);
        clear();

        // Mode 2 sprite vs sprite, then saturation
        pix(2'd2, 2'd3, 8'h10, 9'd60, 9'd70);
        idle();
        chk("m2_single", 32'(HIT), 0);
        pix(2'd2, 2'd0, 8'h90, 9'd61, 9'd71);
        idle();
        chk("m2_mask", 32'(HIT_MASK), 8'h90);
        chk("m2_fch", 32'(FIRST_CH), 4);
        chk("m2_fh", 32'(FIRST_H), 61);
        for (int i = 0; i < 300; i++)
            pix(2'd2, 2'd0, 8'h90, 9'(i % 200 + 10), 9'd72);
        idle();
        chk("sat_cnt", 32'(HIT_CNT), 255);
        chk("sat_fh", 32'(FIRST_H), 61);
        RD = 1'b1; RSEL = 2'd0; #1;
        chk("sat_stat", 32'(DB_out), 8'hC0);
        RD = 1'b0;

        // Clear wins over a simultaneous event and drops the in-flight pixel
        pix(2'd1, 2'd1, 8'h02, 9'd100, 9'd5);
        RESCL = 1'b1;
        pix(2'd1, 2'd1, 8'h04, 9'd101, 9'd5);
        RESCL = 1'b0;
        idle();
        idle();
        all_zero("clr_evt");
        pix(2'd1, 2'd1, 8'h08, 9'd102, 9'd9);
        idle();
        chk("clr_next_fh", 32'(FIRST_H), 102);
        chk("clr_next_fch", 32'(FIRST_CH), 3);
        chk("clr_next_cnt", 32'(HIT_CNT), 1);

        // Asynchronous reset mid-frame discards the pipeline
        pix(2'd1, 2'd1, 8'h01, 9'd110, 9'd10);
        n_RES = 1'b0; #1;
        all_zero("arst");
        #2 n_RES = 1'b1;
        idle();
        idle();
        chk("arst_drop", 32'(HIT), 0);
        pix(2'd1, 2'd1, 8'h40, 9'd120, 9'd11);
        idle();
        chk("arst_fh", 32'(FIRST_H), 120);
        chk("arst_fv", 32'(FIRST_V), 11);
        chk("arst_fch", 32'(FIRST_CH), 6);
        chk("arst_mask", 32'(HIT_MASK), 8'h40);
        chk("arst_cnt", 32'(HIT_CNT), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
